lsu_sized: RTL and testbench
============================

# lsu_sized

Parametrised load/store unit for the RV32I soft core; supersedes the direct ALU-to-data-memory connection used by the single-cycle datapath. Accepts one load or store per request and supports byte, half and word sizes with sign/zero extension. Adds byte-lane write strobes, misalignment and illegal-size detection, a variable-latency memory handshake and a bus timeout. Sits between the ALU address output and the data memory; `busy` stalls the program counter while an access is outstanding.

## Interface
- `ADDR_W`, 32: byte address width, 4..32.
- `TIMEOUT`, 15: maximum cycles to wait for `mem_ack` before a bus error, 1..255.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low. `reset`=0 clears all state immediately.
- `start` in 1: request strobe; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: RV32I size/sign field.
- `addr` in ADDR_W: byte address.
- `store_data` in 32: store source, data in the low bits.
- `busy` out 1: high in ACCESS and DONE.
- `done` out 1: one-cycle completion pulse.
- `load_data` out 32: extended load result; held until the next load completes.
- `fault_misalign` out 1: valid with `done`.
- `fault_illegal` out 1: valid with `done`.
- `fault_bus` out 1: valid with `done`.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: write enable.
- `mem_addr` out ADDR_W: word-aligned address (low 2 bits 0).
- `mem_wstrb` out 4: byte-lane strobes, 0 on reads.
- `mem_wdata` out 32: lane-replicated write data.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in 32: read word, valid with `mem_ack`.

## Operation
- FSM: IDLE, ACCESS, DONE. Reset state IDLE. All outputs 0 at reset, including `load_data`.
- In IDLE with `start`=1, the unit decodes and latches `is_store`, `funct3` and `addr`.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other code sets `fault_illegal` and goes directly to DONE.
- Misalignment: a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0. It sets `fault_misalign` and goes directly to DONE.
- A faulted request issues no memory request. Illegal takes priority over misaligned.
- A legal request goes to ACCESS.
- `mem_req`=1 for the whole of ACCESS. `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` stay stable throughout.
- SB: `mem_wstrb` = 0001 << `addr[1:0]`, byte replicated across all 4 lanes.
- SH: `mem_wstrb` = 0011 << `addr[1:0]`, half replicated across both halves.
- SW: `mem_wstrb` = 1111.
- Loads select the addressed lane of `mem_rdata`. LB and LH sign-extend; LBU and LHU zero-extend.
- On `mem_ack`=1 in ACCESS, the load result is latched into `load_data` (loads only) and the FSM goes to DONE.
- A wait counter resets on entry to ACCESS and increments each cycle without ack. If it reaches `TIMEOUT` without ack, `fault_bus`=1, `load_data` is unchanged, and the FSM goes to DONE.
- An ack arriving in the same cycle the counter reaches `TIMEOUT` counts as success.
- DONE lasts one cycle with `done`=1, then returns to IDLE. Fault flags are high only during DONE.
- `start` is ignored while `busy`=1. `mem_ack` is ignored outside ACCESS.
- Reset asserted mid-access clears the state immediately: `mem_req` drops asynchronously and no `done` is produced.

## Timing
- `start` at edge N (IDLE) gives ACCESS from N+1.
- Zero-wait memory (ack in first ACCESS cycle): `done` at cycle N+2, two-cycle latency.
- k wait cycles: `done` at N+2+k.
- Faulted request: `done` at N+1. `busy` is high only in that cycle.
- Bus timeout: `done` at N+1+TIMEOUT+1.
- The earliest back-to-back `start` is accepted the cycle after DONE. Throughput is at most one access per 3 cycles.
- `load_data` updates on the same edge that enters DONE, so it is valid while `done`=1.

## Test plan
- LB at `addr`=0x103, `mem_rdata`=0x80FF_1234, zero-wait -> `done` 2 cycles after start, `load_data`=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at `addr`=0x202, `store_data`=0x0000_BEEF -> `mem_addr`=0x200, `mem_wstrb`=1100, `mem_wdata`=0xBEEF_BEEF, `mem_we`=1.
- LW at `addr`=0x006 -> `fault_misalign`=1 at N+1, `mem_req` never asserted. Load `funct3`=011 -> `fault_illegal`=1 only.
- `TIMEOUT`=4, no ack -> `fault_bus`=1 with `done` at N+6, `load_data` unchanged. Ack on the 4th wait cycle -> success, no fault.
- LHU at 0x012, ack after 3 waits, `mem_rdata`=0xA5A5_0000 -> `load_data`=0x0000_A5A5, `done` at N+5. A `start` pulsed during ACCESS is ignored.
- `reset`=0 during the 2nd ACCESS cycle -> `mem_req`, `busy` and `done` go to 0 immediately. After release, a new SW completes normally.

Source files
------------

// File: rtl/lsu_sized.sv
// Sized load/store unit for the RV32I core.
// Decodes one load or store per request, checks its size and alignment, and runs
// a variable-latency memory handshake with a bus timeout. Load results are
// lane-selected and sign- or zero-extended.
module lsu_sized #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              fault_misalign,
  output logic              fault_illegal,
  output logic              fault_bus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              fault_misalign_q, fault_misalign_d;
  logic              fault_illegal_q, fault_illegal_d;
  logic              fault_bus_q, fault_bus_d;

  logic              req_illegal, req_misalign;
  logic [31:0]       rshift, load_ext;
  logic [3:0]        strb;
  logic [31:0]       wdata;

  // Classify the incoming request; illegal codes win over misalignment.
  always_comb begin
    req_illegal = 1'b1;
    if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
        default:                req_illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        default:                                req_illegal = 1'b1;
      endcase
    end
    req_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    // Halfword accesses are aligned here, so the shift is 0 or 16 for them.
    rshift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_ext = {24'h000000, rshift[7:0]};
      3'b101:  load_ext = {16'h0000, rshift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Build lane strobes and replicated write data for the latched store.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr_q[1:0];
        wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr_q[1:0];
        wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = sdata_q;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      cnt_q            <= 8'd0;
      store_q          <= 1'b0;
      funct3_q         <= 3'b000;
      addr_q           <= '0;
      sdata_q          <= 32'd0;
      load_data_q      <= 32'd0;
      fault_misalign_q <= 1'b0;
      fault_illegal_q  <= 1'b0;
      fault_bus_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      store_q          <= store_d;
      funct3_q         <= funct3_d;
      addr_q           <= addr_d;
      sdata_q          <= sdata_d;
      load_data_q      <= load_data_d;
      fault_misalign_q <= fault_misalign_d;
      fault_illegal_q  <= fault_illegal_d;
      fault_bus_q      <= fault_bus_d;
    end
  end

  // Next-state: accept in IDLE, wait for ack or timeout in ACCESS, one-cycle DONE.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    store_d          = store_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    sdata_d          = sdata_q;
    load_data_d      = load_data_q;
    // Fault flags are only ever set on the transition into DONE.
    fault_misalign_d = 1'b0;
    fault_illegal_d  = 1'b0;
    fault_bus_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          store_d  = is_store;
          funct3_d = funct3;
          addr_d   = addr;
          sdata_d  = store_data;
          cnt_d    = 8'd0;
          if (req_illegal) begin
            fault_illegal_d = 1'b1;
            state_d         = StDone;
          end else if (req_misalign) begin
            fault_misalign_d = 1'b1;
            state_d          = StDone;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        // Ack in the same cycle the counter hits the limit still succeeds.
        if (mem_ack) begin
          if (!store_q) load_data_d = load_ext;
          state_d = StDone;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          fault_bus_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; memory signals are zero outside ACCESS.
  always_comb begin
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    mem_req        = (state_q == StAccess);
    mem_we         = mem_req && store_q;
    mem_addr       = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wstrb      = mem_we ? strb : 4'b0000;
    mem_wdata      = mem_we ? wdata : 32'd0;
    load_data      = load_data_q;
    fault_misalign = fault_misalign_q;
    fault_illegal  = fault_illegal_q;
    fault_bus      = fault_bus_q;
  end

endmodule

// File: tb/tb_lsu_sized.sv
// Directed bench for lsu_sized with TIMEOUT=4 and a scripted memory responder.
module tb_lsu_sized;

  logic        clk, reset, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault_misalign, fault_illegal, fault_bus;
  logic [31:0] load_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  // Results captured by run_op.
  int          r_lat;
  logic        r_req, r_stable, r_fm, r_fi, r_fb, r_busy, r_we;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0]  r_strb;

  lsu_sized #(
    .ADDR_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .is_store      (is_store),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .busy          (busy),
    .done          (done),
    .load_data     (load_data),
    .fault_misalign(fault_misalign),
    .fault_illegal (fault_illegal),
    .fault_bus     (fault_bus),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Issue one request; ack after 'waits' non-ack ACCESS cycles (-1 = never).
  // Latency is counted in cycles from the edge that samples start.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int waits, input logic [31:0] rd,
                        input logic poke);
    int  nw;
    logic first;
    nw = 0; first = 1'b1;
    r_lat = 99; r_req = 0; r_stable = 1; r_fm = 0; r_fi = 0; r_fb = 0; r_busy = 0;
    r_we = 0; r_addr = 0; r_wdata = 0; r_strb = 0; r_ld = 0;
    is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start = poke && (c == 2);
      if (done) begin
        r_lat = c; r_fm = fault_misalign; r_fi = fault_illegal; r_fb = fault_bus;
        r_ld = load_data; r_busy = busy;
        break;
      end
      if (mem_req) begin
        if (first) begin
          r_addr = mem_addr; r_strb = mem_wstrb; r_wdata = mem_wdata; r_we = mem_we;
          first = 1'b0;
        end else if (mem_addr !== r_addr || mem_wstrb !== r_strb ||
                     mem_wdata !== r_wdata || mem_we !== r_we) begin
          r_stable = 1'b0;
        end
        r_req = 1'b1;
        mem_rdata = rd;
        mem_ack = (waits >= 0) && (nw == waits);
        if (!mem_ack) nw++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'd0;
    store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_load_data", load_data, 32'd0);
    check_eq("rst_mem", {mem_req, mem_we, mem_wstrb, fault_misalign, fault_illegal, fault_bus},
             32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // LB / LBU at lane 3
    run_op(1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h80FF_1234, 1'b0);
    check_eq("lb_lat", r_lat, 32'd2);
    check_eq("lb_data", r_ld, 32'hFFFF_FF80);
    check_eq("lb_addr", r_addr, 32'h100);
    check_eq("lb_we_strb", {r_we, r_strb}, 32'd0);
    run_op(1'b0, 3'b100, 32'h103, 32'd0, 0, 32'h80FF_1234, 1'b0);
    check_eq("lbu_data", r_ld, 32'h0000_0080);

    // SH upper half, one wait cycle to observe stability
    run_op(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 1, 32'd0, 1'b0);
    check_eq("sh_addr", r_addr, 32'h200);
    check_eq("sh_strb", r_strb, 32'b1100);
    check_eq("sh_wdata", r_wdata, 32'hBEEF_BEEF);
    check_eq("sh_we", r_we, 32'd1);
    check_eq("sh_stable", r_stable, 32'd1);
    check_eq("sh_lat", r_lat, 32'd3);
    check_eq("sh_keeps_ld", load_data, 32'h0000_0080);

    // SB lane 1
    run_op(1'b1, 3'b000, 32'h001, 32'h1234_56A7, 0, 32'd0, 1'b0);
    check_eq("sb_strb", r_strb, 32'b0010);
    check_eq("sb_wdata", r_wdata, 32'hA7A7_A7A7);

    // LH sign-extension from the upper half
    run_op(1'b0, 3'b001, 32'h002, 32'd0, 0, 32'h8001_0000, 1'b0);
    check_eq("lh_data", r_ld, 32'hFFFF_8001);

    // Misaligned LW
    run_op(1'b0, 3'b010, 32'h006, 32'd0, 0, 32'd0, 1'b0);
    check_eq("mis_flags", {r_fi, r_fm, r_fb}, 32'b010);
    check_eq("mis_lat", r_lat, 32'd1);
    check_eq("mis_noreq", r_req, 32'd0);
    check_eq("mis_busy", r_busy, 32'd1);

    // Illegal load code
    run_op(1'b0, 3'b011, 32'h000, 32'd0, 0, 32'd0, 1'b0);
    check_eq("ill_flags", {r_fi, r_fm, r_fb}, 32'b100);
    check_eq("ill_lat", r_lat, 32'd1);
    check_eq("ill_noreq", r_req, 32'd0);

    // Illegal store code on a misaligned address: illegal wins
    run_op(1'b1, 3'b101, 32'h001, 32'd0, 0, 32'd0, 1'b0);
    check_eq("ill_prio_flags", {r_fi, r_fm, r_fb}, 32'b100);

    // Bus timeout, load_data unchanged
    run_op(1'b0, 3'b010, 32'h010, 32'd0, -1, 32'hDEAD_DEAD, 1'b0);
    check_eq("to_flags", {r_fi, r_fm, r_fb}, 32'b001);
    check_eq("to_lat", r_lat, 32'd6);
    check_eq("to_ld", r_ld, 32'hFFFF_8001);

    // Ack in the cycle the counter reaches TIMEOUT
    run_op(1'b0, 3'b010, 32'h010, 32'd0, 4, 32'h1234_5678, 1'b0);
    check_eq("late_ack_flags", {r_fi, r_fm, r_fb}, 32'b000);
    check_eq("late_ack_lat", r_lat, 32'd6);
    check_eq("late_ack_ld", r_ld, 32'h1234_5678);

    // LHU after 3 waits with a stray start during ACCESS
    run_op(1'b0, 3'b101, 32'h012, 32'd0, 3, 32'hA5A5_0000, 1'b1);
    check_eq("lhu_data", r_ld, 32'h0000_A5A5);
    check_eq("lhu_lat", r_lat, 32'd5);
    check_eq("lhu_idle_after", {busy, done}, 32'd0);

    // Reset in the 2nd ACCESS cycle
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_req", mem_req, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst", {mem_req, busy, done}, 32'd0);
    check_eq("async_rst_ld", load_data, 32'd0);
    @(posedge clk); #1;
    check_eq("rst_no_done", {busy, done}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 3'b010, 32'h004, 32'hDEAD_BEEF, 0, 32'd0, 1'b0);
    check_eq("sw_lat", r_lat, 32'd2);
    check_eq("sw_strb", r_strb, 32'b1111);
    check_eq("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    check_eq("sw_addr", r_addr, 32'h004);
    check_eq("sw_flags", {r_fi, r_fm, r_fb}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
